reg_file_en: RTL and testbench
==============================

# reg_file_en

Parametrised multi-entry register file with global enable, one write port and two independent read ports, each with optional output registering and write-to-read forwarding. It generalises the single 8-bit enabled flip-flop into the processor datapath's general-purpose register bank. It feeds operand fetch and takes writeback from the execute stage.

## Interface
Parameters:
- WIDTH, 8, data width of every entry
- DEPTH, 8, number of entries (2..256); AW = max(1, clog2(DEPTH)) derived
- READ_REG, 0, 0 = combinational read (latency 0), 1 = registered read (latency 1)
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read (write-first), 0 = read-first
- ZERO_REG, 0, 1 = entry 0 reads constant 0 and ignores writes
- RESET_VAL, 0, WIDTH-bit value loaded into every entry on reset

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- en  in  1  global enable; 0 blocks writes and freezes registered read outputs
- we  in  1  write request
- waddr  in  AW  write address
- wdata  in  WIDTH  write data
- raddr_a  in  AW  read port A address
- rdata_a  out  WIDTH  read port A data
- raddr_b  in  AW  read port B address
- rdata_b  out  WIDTH  read port B data

## Operation
- Write: on rising clk with rst=0, en=1, we=1 and waddr < DEPTH, entry[waddr] <= wdata. Otherwise no entry changes.
- ZERO_REG=1: writes to address 0 are dropped, and reads of address 0 return 0 regardless of BYPASS.
- Out-of-range address (waddr or raddr >= DEPTH, possible when DEPTH is not a power of 2): write ignored, read returns 0.
- Read value selection per port:
  - Forwarded wdata if BYPASS=1, en=1, we=1, raddr == waddr, and the address is in range and writable.
  - Otherwise the stored entry.
- READ_REG=0: rdata_x is the selected value, combinational.
- READ_REG=1: rdata_x <= selected value on each clk edge where en=1; holds when en=0.
- Ports A and B are fully independent and may read the same address simultaneously.
- Reset: every entry <= RESET_VAL. With READ_REG=1, rdata_a and rdata_b <= 0. Reset dominates en and we.

## Timing
- Write-to-storage latency: 1 cycle. Data is visible in the stored entry after the write edge.
- READ_REG=0:
  - BYPASS=1: rdata reflects a same-cycle write immediately.
  - BYPASS=0: rdata shows the old value until after the edge.
- READ_REG=1: rdata updates 1 cycle after the address is presented.
  - BYPASS=1: a coincident write returns the new data.
  - BYPASS=0: a coincident write returns the old data.
- en deasserted mid-sequence: pending write is lost (not queued); registered outputs hold their last value; storage is untouched.
- rst asserted in the same cycle as we=1: write discarded; the entry ends at RESET_VAL.
- READ_REG=0 outputs after reset: equal to the entry contents, i.e. RESET_VAL, or 0 for address 0 when ZERO_REG=1 or for out-of-range addresses.
- No combinational path from rdata to any input. With READ_REG=1, no path from inputs to outputs.

## Structure
- Shared package reg_file_pkg:
  - Default WIDTH/DEPTH constants.
  - Address-width function: max(1, clog2(n)).
  - Read-mode encodings (READ_COMB=0, READ_REGD=1).
- Sub-module reg_file_read_port: address decode, range check, zero-register handling, bypass compare, and optional output register. Instantiated once per read port.
- Top level holds the storage array and the write decode.

## Test plan
- Reset then read (WIDTH=8, DEPTH=8, RESET_VAL=8'h00): rst=1 for 2 cycles -> all 8 addresses read 8'h00 on both ports; registered rdata = 8'h00.
- Basic write/read with en: en=1, we=1, waddr=3, wdata=8'hB3 -> after edge, raddr_a=3 gives 8'hB3. Then en=0, we=1, waddr=3, wdata=8'h93 -> entry 3 stays 8'hB3.
- Bypass, READ_REG=0, BYPASS=1: we=1, waddr=5, wdata=8'h45, raddr_b=5 in the same cycle -> rdata_b=8'h45 before the edge. With BYPASS=0 -> rdata_b shows the old value (8'h00) until after the edge.
- Registered read, READ_REG=1: raddr_a=3 at edge N -> rdata_a=8'hB3 after edge N, not before. en=0 at edge N+1 with raddr_a=5 -> rdata_a holds 8'hB3.
- ZERO_REG=1: write 8'hFF to address 0 -> both ports read 8'h00 at address 0, including the same cycle with BYPASS=1.
- Reset mid-operation and out-of-range (DEPTH=6):
  - rst=1 in the same cycle as a write of 8'h45 to address 2 -> entry 2 = RESET_VAL.
  - Write to address 7 -> ignored; raddr=7 reads 8'h00.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the general-purpose register bank.
package reg_file_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    // Read-port output modes
    localparam int READ_COMB = 0;
    localparam int READ_REGD = 1;

    // Address width for n entries, never narrower than one bit
    function automatic int addr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One read port: range check, zero-register masking, write forwarding,
// and an optional output register.
module reg_file_read_port
    import reg_file_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int READ_REG = READ_COMB,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0,
    localparam int AW      = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr_fire,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] mem [DEPTH],
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic             in_range;
    logic             zero_hit;
    logic             fwd_hit;
    logic [WIDTH-1:0] sel;

    // Pick forwarded write data, stored entry, or zero for this address.
    // wr_fire already implies the write address is in range and writable.
    always_comb begin
        in_range = ({1'b0, raddr} < (AW+1)'(DEPTH));
        zero_hit = (ZERO_REG != 0) && (raddr == '0);
        fwd_hit  = (BYPASS != 0) && wr_fire && (raddr == waddr);
        sel      = '0;
        if (in_range && !zero_hit) begin
            sel = fwd_hit ? wdata : mem[raddr];
        end
    end

    if (READ_REG == READ_REGD) begin : g_reg
        // Registered read: capture the selection while enabled, hold otherwise
        always_ff @(posedge clk) begin
            if (rst) begin
                rdata <= '0;
            end else if (en) begin
                rdata <= sel;
            end
        end
    end else begin : g_comb
        logic unused_ctl;
        assign unused_ctl = clk ^ rst ^ en;
        // Combinational read: selection goes straight to the output
        always_comb begin
            rdata = sel;
        end
    end

endmodule

// File: rtl/reg_file_en.sv
// General-purpose register bank: storage array and write decode, with two
// independent read ports.
module reg_file_en
    import reg_file_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               DEPTH     = DEF_DEPTH,
    parameter int               READ_REG  = READ_COMB,
    parameter int               BYPASS    = 1,
    parameter int               ZERO_REG  = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              AW        = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             w_in_range;
    logic             w_zero;
    logic             wr_fire;

    // Write qualifies only when enabled, in range and not aimed at a hardwired zero
    always_comb begin
        w_in_range = ({1'b0, waddr} < (AW+1)'(DEPTH));
        w_zero     = (ZERO_REG != 0) && (waddr == '0);
        wr_fire    = en && we && w_in_range && !w_zero;
    end

    // Storage update; reset overrides any coincident write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[AW'(i)] <= RESET_VAL;
            end
        end else if (wr_fire) begin
            mem[waddr] <= wdata;
        end
    end

    reg_file_read_port #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .READ_REG (READ_REG),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
    ) u_port_a (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .wr_fire (wr_fire),
        .waddr   (waddr),
        .wdata   (wdata),
        .mem     (mem),
        .raddr   (raddr_a),
        .rdata   (rdata_a)
    );

    reg_file_read_port #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .READ_REG (READ_REG),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
    ) u_port_b (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .wr_fire (wr_fire),
        .waddr   (waddr),
        .wdata   (wdata),
        .mem     (mem),
        .raddr   (raddr_b),
        .rdata   (rdata_b)
    );

endmodule

// File: tb/tb_reg_file_en.sv
// Directed bench for reg_file_en: six configurations share one stimulus stream.
module tb_reg_file_en;

    localparam int BASE = 0;  // comb read, bypass
    localparam int RF   = 1;  // comb read, read-first
    localparam int RD   = 2;  // registered read, bypass
    localparam int RDNB = 3;  // registered read, read-first
    localparam int ZR   = 4;  // zero register, bypass
    localparam int D6   = 5;  // DEPTH=6, RESET_VAL=8'h5A

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       we = 1'b0;
    logic [2:0] waddr = '0;
    logic [7:0] wdata = '0;
    logic [2:0] raddr_a = '0;
    logic [2:0] raddr_b = '0;
    logic [7:0] ra [6];
    logic [7:0] rb [6];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    reg_file_en u_base (.clk(clk), .rst(rst), .en(en), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(ra[BASE]), .raddr_b(raddr_b), .rdata_b(rb[BASE]));

    reg_file_en #(.BYPASS(0)) u_rf (.clk(clk), .rst(rst), .en(en), .we(we), .waddr(waddr),
        .wdata(wdata), .raddr_a(raddr_a), .rdata_a(ra[RF]), .raddr_b(raddr_b), .rdata_b(rb[RF]));

    reg_file_en #(.READ_REG(1)) u_rd (.clk(clk), .rst(rst), .en(en), .we(we), .waddr(waddr),
        .wdata(wdata), .raddr_a(raddr_a), .rdata_a(ra[RD]), .raddr_b(raddr_b), .rdata_b(rb[RD]));

    reg_file_en #(.READ_REG(1), .BYPASS(0)) u_rdnb (.clk(clk), .rst(rst), .en(en), .we(we),
        .waddr(waddr), .wdata(wdata), .raddr_a(raddr_a), .rdata_a(ra[RDNB]),
        .raddr_b(raddr_b), .rdata_b(rb[RDNB]));

    reg_file_en #(.ZERO_REG(1)) u_zero (.clk(clk), .rst(rst), .en(en), .we(we), .waddr(waddr),
        .wdata(wdata), .raddr_a(raddr_a), .rdata_a(ra[ZR]), .raddr_b(raddr_b), .rdata_b(rb[ZR]));

    reg_file_en #(.DEPTH(6), .RESET_VAL(8'h5A)) u_d6 (.clk(clk), .rst(rst), .en(en), .we(we),
        .waddr(waddr), .wdata(wdata), .raddr_a(raddr_a), .rdata_a(ra[D6]),
        .raddr_b(raddr_b), .rdata_b(rb[D6]));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [7:0] exp_d6;
        rst = 1'b1; en = 1'b0; we = 1'b0;
        tick; tick;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            raddr_a = 3'(i); raddr_b = 3'(i);
            #1;
            vectors++;
            if (ra[BASE] !== 8'h00) begin miscompares++; $display("FAIL reset_base_a[%0d] got %h exp 00", i, ra[BASE]); end
            vectors++;
            if (rb[BASE] !== 8'h00) begin miscompares++; $display("FAIL reset_base_b[%0d] got %h exp 00", i, rb[BASE]); end
            exp_d6 = (i < 6) ? 8'h5A : 8'h00;
            vectors++;
            if (ra[D6] !== exp_d6) begin miscompares++; $display("FAIL reset_d6_a[%0d] got %h exp %h", i, ra[D6], exp_d6); end
        end
        vectors++;
        if (ra[RD] !== 8'h00) begin miscompares++; $display("FAIL reset_regd_a got %h exp 00", ra[RD]); end
        vectors++;
        if (rb[RDNB] !== 8'h00) begin miscompares++; $display("FAIL reset_regd_b got %h exp 00", rb[RDNB]); end
    endtask

    task automatic test_write_en;
        en = 1'b1; we = 1'b1; waddr = 3'd3; wdata = 8'hB3; raddr_a = 3'd3;
        tick;
        we = 1'b0;
        #1;
        vectors++;
        if (ra[BASE] !== 8'hB3) begin miscompares++; $display("FAIL write_base got %h exp b3", ra[BASE]); end
        vectors++;
        if (ra[RF] !== 8'hB3) begin miscompares++; $display("FAIL write_rf got %h exp b3", ra[RF]); end
        en = 1'b0; we = 1'b1; wdata = 8'h93;
        #1;
        vectors++;
        if (ra[BASE] !== 8'hB3) begin miscompares++; $display("FAIL disabled_no_fwd got %h exp b3", ra[BASE]); end
        tick;
        en = 1'b1; we = 1'b0;
        #1;
        vectors++;
        if (ra[BASE] !== 8'hB3) begin miscompares++; $display("FAIL disabled_no_write got %h exp b3", ra[BASE]); end
    endtask

    task automatic test_bypass;
        en = 1'b1; we = 1'b1; waddr = 3'd5; wdata = 8'h45; raddr_b = 3'd5;
        #1;
        vectors++;
        if (rb[BASE] !== 8'h45) begin miscompares++; $display("FAIL bypass_fwd got %h exp 45", rb[BASE]); end
        vectors++;
        if (rb[RF] !== 8'h00) begin miscompares++; $display("FAIL readfirst_old got %h exp 00", rb[RF]); end
        tick;
        we = 1'b0;
        #1;
        vectors++;
        if (rb[RF] !== 8'h45) begin miscompares++; $display("FAIL readfirst_after got %h exp 45", rb[RF]); end
    endtask

    task automatic test_registered;
        en = 1'b1; we = 1'b0; raddr_a = 3'd0;
        tick;
        raddr_a = 3'd3;
        #1;
        vectors++;
        if (ra[RD] !== 8'h00) begin miscompares++; $display("FAIL regd_not_early got %h exp 00", ra[RD]); end
        tick;
        vectors++;
        if (ra[RD] !== 8'hB3) begin miscompares++; $display("FAIL regd_latency got %h exp b3", ra[RD]); end
        en = 1'b0; raddr_a = 3'd5;
        tick;
        vectors++;
        if (ra[RD] !== 8'hB3) begin miscompares++; $display("FAIL regd_hold got %h exp b3", ra[RD]); end
        en = 1'b1;
        tick;
        vectors++;
        if (ra[RD] !== 8'h45) begin miscompares++; $display("FAIL regd_resume got %h exp 45", ra[RD]); end
        we = 1'b1; waddr = 3'd6; wdata = 8'h66; raddr_a = 3'd6;
        tick;
        we = 1'b0;
        vectors++;
        if (ra[RD] !== 8'h66) begin miscompares++; $display("FAIL regd_bypass got %h exp 66", ra[RD]); end
        vectors++;
        if (ra[RDNB] !== 8'h00) begin miscompares++; $display("FAIL regd_readfirst got %h exp 00", ra[RDNB]); end
        tick;
        vectors++;
        if (ra[RDNB] !== 8'h66) begin miscompares++; $display("FAIL regd_readfirst_next got %h exp 66", ra[RDNB]); end
    endtask

    task automatic test_zero_reg;
        en = 1'b1; we = 1'b1; waddr = 3'd0; wdata = 8'hFF; raddr_a = 3'd0; raddr_b = 3'd0;
        #1;
        vectors++;
        if (ra[ZR] !== 8'h00) begin miscompares++; $display("FAIL zero_same_a got %h exp 00", ra[ZR]); end
        vectors++;
        if (rb[ZR] !== 8'h00) begin miscompares++; $display("FAIL zero_same_b got %h exp 00", rb[ZR]); end
        tick;
        we = 1'b0;
        #1;
        vectors++;
        if (ra[ZR] !== 8'h00) begin miscompares++; $display("FAIL zero_after_a got %h exp 00", ra[ZR]); end
        vectors++;
        if (rb[ZR] !== 8'h00) begin miscompares++; $display("FAIL zero_after_b got %h exp 00", rb[ZR]); end
        vectors++;
        if (ra[BASE] !== 8'hFF) begin miscompares++; $display("FAIL entry0_normal got %h exp ff", ra[BASE]); end
    endtask

    task automatic test_reset_and_range;
        en = 1'b1; we = 1'b1; waddr = 3'd2; wdata = 8'h11; raddr_a = 3'd2;
        tick;
        we = 1'b0;
        #1;
        vectors++;
        if (ra[D6] !== 8'h11) begin miscompares++; $display("FAIL d6_write got %h exp 11", ra[D6]); end
        rst = 1'b1; we = 1'b1; wdata = 8'h45;
        tick;
        rst = 1'b0; we = 1'b0;
        #1;
        vectors++;
        if (ra[D6] !== 8'h5A) begin miscompares++; $display("FAIL rst_beats_write got %h exp 5a", ra[D6]); end
        vectors++;
        if (ra[BASE] !== 8'h00) begin miscompares++; $display("FAIL rst_base got %h exp 00", ra[BASE]); end
        vectors++;
        if (ra[RD] !== 8'h00) begin miscompares++; $display("FAIL rst_regd got %h exp 00", ra[RD]); end
        we = 1'b1; waddr = 3'd7; wdata = 8'h77; raddr_b = 3'd7;
        #1;
        vectors++;
        if (rb[D6] !== 8'h00) begin miscompares++; $display("FAIL oor_no_fwd got %h exp 00", rb[D6]); end
        vectors++;
        if (rb[BASE] !== 8'h77) begin miscompares++; $display("FAIL inrange_fwd7 got %h exp 77", rb[BASE]); end
        tick;
        we = 1'b0;
        #1;
        vectors++;
        if (rb[D6] !== 8'h00) begin miscompares++; $display("FAIL oor_read got %h exp 00", rb[D6]); end
        vectors++;
        if (rb[BASE] !== 8'h77) begin miscompares++; $display("FAIL base_entry7 got %h exp 77", rb[BASE]); end
        raddr_b = 3'd5;
        #1;
        vectors++;
        if (rb[D6] !== 8'h5A) begin miscompares++; $display("FAIL d6_entry5 got %h exp 5a", rb[D6]); end
    endtask

    initial begin
        test_reset;
        test_write_en;
        test_bypass;
        test_registered;
        test_zero_reg;
        test_reset_and_range;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
